uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
Parametrised successor UART transmitter: configurable data width, parity mode, stop-bit count and baud divisor, with a valid/ready input handshake. Includes a one-entry holding register so back-to-back words go out with no idle gap between frames. Sits between an internal byte/word source (FIFO read side, command engine) and the external TX pin.

Parameters:
CLKDIV, 128, clock cycles per UART bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
tx_valid  input  1  source presents a word on tx_data
tx_ready  output  1  holding register empty; word accepted on a cycle where tx_valid && tx_ready
tx_data  input  DATA_BITS  word to send, LSB transmitted first
tx_pin  output  1  serial line, idle high
tx_busy  output  1  a frame is on the line, start bit through last stop bit
tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit

Behaviour:
- Reset (rst == 0 at a clock edge): tx_pin = 1, tx_busy = 0, tx_done = 0, tx_ready = 1, holding register empty, shifter idle, bit and baud counters = 0. Reset mid-frame aborts the frame; the line returns high on the next cycle and the held word is discarded.
- Frame format: 1 start (0), DATA_BITS data LSB-first, parity bit if PARITY != 0, STOP_BITS stop (1). NBITS = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS. Each bit is held exactly CLKDIV cycles; a frame lasts NBITS*CLKDIV cycles.
- Parity: even = XOR of the data bits; odd = inverted XOR. Computed when the word is loaded into the shifter.
- Handshake: the accept condition is tx_valid && tx_ready at the clock edge. The word is latched into the holding register, and tx_ready goes 0 on the next cycle. tx_data is don't-care at all other times.
- States: IDLE, SHIFT. Baud counter counts down from CLKDIV-1 to 0. Bit counter counts the bits remaining.
- IDLE -> SHIFT: on the cycle after the holding register becomes full, the holding register moves to the shifter, tx_pin = 0, tx_busy = 1, and tx_ready returns to 1. Latency from the accept edge to the start bit on tx_pin is 2 cycles.
- SHIFT: when the baud counter reaches 0 and bits remain, advance to the next bit and reload CLKDIV-1.
- End of frame: on the final cycle of the last stop bit, tx_done = 1 for that cycle.
  - If the holding register is full, load the next frame so its start bit begins on the immediately following cycle. tx_busy stays 1 with no idle gap.
  - Otherwise go to IDLE: tx_busy = 0 and tx_pin = 1 from the next cycle.
- Simultaneous events: an accept on the same cycle the holding register drains into the shifter is impossible by construction, because tx_ready is 0 while the holding register is full. An accept on the end-of-frame cycle with an empty holding register is legal; the new frame starts 2 cycles later (1 idle-high cycle minimum).
- tx_valid held high continuously gives gapless back-to-back frames. At most one word is outstanding beyond the one shifting.
- Width rules: the baud counter is clog2(CLKDIV) bits wide. The bit counter is 4 bits wide, which covers the maximum NBITS = 13.

Test Plan:
1. CLKDIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; send 0xA5 -> tx_pin sequence 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles total); start bit 2 cycles after the accept; tx_done pulses on cycle 44 of the frame.
2. Same config with PARITY=1, send 0x00 -> parity bit = 1; with PARITY=0, send 0xFF -> 10-bit frame, 40 cycles.
3. DATA_BITS=7, STOP_BITS=2, tx_valid held high with words 0x55, 0x2A, 0x7F -> three frames with no idle cycle between them; tx_ready low while the holding register is full; tx_busy continuously 1; 3 tx_done pulses.
4. Assert rst=0 during data bit 3 of a frame with a held word pending -> next cycle tx_pin=1, tx_busy=0, tx_ready=1; no further frame is sent after rst is released.
5. Word accepted exactly on the tx_done cycle with an empty holding register -> exactly one idle-high cycle, then the start bit; with tx_valid=0, tx_pin stays 1 indefinitely.
6. CLKDIV=2 boundary: send 0x01 -> each bit is 2 cycles; the frame length matches NBITS*2 exactly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter with a one-word holding register ahead of the frame shifter.
// Back-to-back words leave with no idle gap between frames.
module uart_tx_frame #(
  parameter int unsigned CLKDIV    = 128,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_pin,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned PAR_BITS = (PARITY != 0) ? 1 : 0;
  localparam int unsigned NBITS    = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int unsigned BAUD_W   = $clog2(CLKDIV);
  localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKDIV - 1);
  localparam logic [3:0]        BITS_INIT = 4'(NBITS);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [NBITS-1:0]     shreg_q, shreg_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done_q, tx_done_d;
  logic                 load;

  // Whole frame laid out LSB-first: start, data, optional parity, stop bits.
  function automatic logic [NBITS-1:0] build_frame(input logic [DATA_BITS-1:0] data);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_BITS:1] = data;
    if (PARITY == 1) begin
      f[DATA_BITS+1] = ~(^data);
    end else if (PARITY == 2) begin
      f[DATA_BITS+1] = ^data;
    end
    return f;
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    baud_d      = baud_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BAUD_W'(1);
        end else if (bit_cnt_q != 4'd1) begin
          baud_d    = BAUD_MAX;
          bit_cnt_d = bit_cnt_q - 4'd1;
          shreg_d   = {1'b1, shreg_q[NBITS-1:1]};
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d   = IDLE;
          baud_d    = '0;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Drain and accept are mutually exclusive: ready is low while the holding register is full.
    if (load) begin
      state_d     = SHIFT;
      shreg_d     = build_frame(hold_q);
      baud_d      = BAUD_MAX;
      bit_cnt_d   = BITS_INIT;
      hold_full_d = 1'b0;
    end
    if (tx_valid && tx_ready_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    tx_pin_d   = (state_d == SHIFT) ? shreg_d[0] : 1'b1;
    tx_busy_d  = (state_d == SHIFT);
    tx_ready_d = ~hold_full_d;
    tx_done_d  = (state_d == SHIFT) && (bit_cnt_d == 4'd1) && (baud_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '1;
      baud_q      <= '0;
      bit_cnt_q   <= '0;
      tx_pin_q    <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      baud_q      <= baud_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_pin_q    <= tx_pin_d;
      tx_busy_q   <= tx_busy_d;
      tx_ready_q  <= tx_ready_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_pin   = tx_pin_q;
  assign tx_busy  = tx_busy_q;
  assign tx_ready = tx_ready_q;
  assign tx_done  = tx_done_q;

endmodule
